am_class_accuracy_tally: RTL and testbench

Parametrised successor to the single-count accuracy tally in the associative-memory (AM) back end. It keeps a global correct/seen count and a correct/seen count for each class, driven by a small control FSM. At end of test set it streams the per-class results out over a valid/ready port. It sits after the AM class-inference stage and is read by the test controller/host.

---
 rtl/am_pkg.sv | 17 +
 rtl/am_tally_counter.sv | 44 ++++
 rtl/am_class_accuracy_tally.sv | 180 ++++++++++++++++++
 tb/tb_am_class_accuracy_tally.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/am_pkg.sv
// rtl/am_pkg.sv - shared types and default sizes for the AM class accuracy tally
package am_pkg;

  // Control states of the tally
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TALLY   = 2'd1,
    READOUT = 2'd2
  } state_t;

  localparam int AM_NUM_CLASSES = 26;
  localparam int AM_CLASS_W     = 5;
  localparam int AM_CNT_W       = 11;

  typedef logic [AM_CLASS_W-1:0] class_t;

endpackage

// File: rtl/am_tally_counter.sv
// rtl/am_tally_counter.sv - CNT_W tally counter with sync clear; TALLY_SATURATE_EN selects saturate vs wrap
module am_tally_counter
  import am_pkg::*;
#(
  parameter int CNT_W = AM_CNT_W
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins over increment
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
`ifdef TALLY_SATURATE_EN
      if (count_q != {CNT_W{1'b1}}) begin
        count_d = count_q + CNT_W'(1);
      end
`else
      count_d = count_q + CNT_W'(1);
`endif
    end
  end

  // Count register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/am_class_accuracy_tally.sv
// rtl/am_class_accuracy_tally.sv - global and per-class accuracy tally with streamed readout (TALLY_SATURATE_EN in counters)
module am_class_accuracy_tally
  import am_pkg::*;
#(
  parameter int NUM_CLASSES = AM_NUM_CLASSES,
  parameter int CLASS_W     = AM_CLASS_W,
  parameter int CNT_W       = AM_CNT_W
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  input  logic               tally_valid,
  input  logic [CLASS_W-1:0] correct_class,
  input  logic [CLASS_W-1:0] class_inference,
  input  logic               tally_done,
  output logic [CNT_W-1:0]   total_correct,
  output logic [CNT_W-1:0]   total_seen,
  output logic               label_err,
  output logic               busy,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [CLASS_W-1:0] rd_class,
  output logic [CNT_W-1:0]   rd_correct,
  output logic [CNT_W-1:0]   rd_total,
  output logic               readout_done
);

  localparam logic [31:0] NUM_CLASSES_U = NUM_CLASSES;

  state_t             state_q, state_d;
  logic [CLASS_W-1:0] idx_q, idx_d;
  logic               rd_valid_q, rd_valid_d;
  logic               readout_done_q, readout_done_d;
  logic               busy_q, busy_d;
  logic               label_err_q, label_err_d;

  logic                   in_range;
  logic                   is_match;
  logic                   take;
  logic                   handshake;
  logic                   last_idx;
  logic [NUM_CLASSES-1:0] class_hit;
  logic [CNT_W-1:0]       cls_correct [NUM_CLASSES];
  logic [CNT_W-1:0]       cls_total   [NUM_CLASSES];

  // A sample is only counted in TALLY, and a concurrent start discards it
  assign in_range  = {{(32-CLASS_W){1'b0}}, correct_class} < NUM_CLASSES_U;
  assign is_match  = (class_inference == correct_class);
  assign take      = (state_q == TALLY) && tally_valid && !start;
  assign handshake = (state_q == READOUT) && rd_valid_q && rd_ready;
  assign last_idx  = ({{(32-CLASS_W){1'b0}}, idx_q} == (NUM_CLASSES_U - 32'd1));

  // One-hot select of the per-class counter pair owning this sample
  always_comb begin
    class_hit = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (take && in_range && (correct_class == CLASS_W'(i))) begin
        class_hit[i] = 1'b1;
      end
    end
  end

  am_tally_counter #(.CNT_W(CNT_W)) u_seen (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (start),
    .inc   (take),
    .count (total_seen)
  );

  am_tally_counter #(.CNT_W(CNT_W)) u_correct (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (start),
    .inc   (take && is_match),
    .count (total_correct)
  );

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_cls
    am_tally_counter #(.CNT_W(CNT_W)) u_cls_total (
      .clk   (clk),
      .nrst  (nrst),
      .clr   (start),
      .inc   (class_hit[g]),
      .count (cls_total[g])
    );

    am_tally_counter #(.CNT_W(CNT_W)) u_cls_correct (
      .clk   (clk),
      .nrst  (nrst),
      .clr   (start),
      .inc   (class_hit[g] && is_match),
      .count (cls_correct[g])
    );
  end

  // Control FSM next state; start has priority in every non-idle state
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    rd_valid_d     = rd_valid_q;
    readout_done_d = 1'b0;
    label_err_d    = label_err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = TALLY;
          label_err_d = 1'b0;
        end
      end
      TALLY: begin
        if (start) begin
          label_err_d = 1'b0;
        end else begin
          if (take && !in_range) begin
            label_err_d = 1'b1;
          end
          if (tally_done) begin
            state_d = READOUT;
            idx_d   = '0;
          end
        end
      end
      READOUT: begin
        if (start) begin
          state_d     = TALLY;
          rd_valid_d  = 1'b0;
          label_err_d = 1'b0;
          idx_d       = '0;
        end else if (handshake) begin
          if (last_idx) begin
            state_d        = IDLE;
            rd_valid_d     = 1'b0;
            readout_done_d = 1'b1;
            idx_d          = '0;
          end else begin
            idx_d = idx_q + CLASS_W'(1);
          end
        end else begin
          // First record appears one cycle after entering READOUT
          rd_valid_d = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        rd_valid_d = 1'b0;
        idx_d      = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM and registered status outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      rd_valid_q     <= 1'b0;
      readout_done_q <= 1'b0;
      busy_q         <= 1'b0;
      label_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      rd_valid_q     <= rd_valid_d;
      readout_done_q <= readout_done_d;
      busy_q         <= busy_d;
      label_err_q    <= label_err_d;
    end
  end

  assign label_err    = label_err_q;
  assign busy         = busy_q;
  assign rd_valid     = rd_valid_q;
  assign readout_done = readout_done_q;
  assign rd_class     = idx_q;
  assign rd_correct   = cls_correct[idx_q];
  assign rd_total     = cls_total[idx_q];

endmodule

// File: tb/tb_am_class_accuracy_tally.sv
// tb/tb_am_class_accuracy_tally.sv - self-checking bench for am_class_accuracy_tally
module tb_am_class_accuracy_tally;

  localparam int N  = 26;
  localparam int CW = 5;
  localparam int W  = 11;

  logic          clk;
  logic          nrst;
  logic          start, tally_valid, tally_done, rd_ready;
  logic [CW-1:0] correct_class, class_inference;
  logic [W-1:0]  total_correct, total_seen, rd_correct, rd_total;
  logic          label_err, busy, rd_valid, readout_done;
  logic [CW-1:0] rd_class;

  logic          s_start, s_valid, s_done, s_rdy;
  logic [1:0]    s_cc, s_ci, s_rd_class;
  logic [3:0]    s_total_correct, s_total_seen, s_rd_correct, s_rd_total;
  logic          s_label_err, s_busy, s_rd_valid, s_readout_done;

  am_class_accuracy_tally #(.NUM_CLASSES(N), .CLASS_W(CW), .CNT_W(W)) dut (
    .clk             (clk),
    .nrst            (nrst),
    .start           (start),
    .tally_valid     (tally_valid),
    .correct_class   (correct_class),
    .class_inference (class_inference),
    .tally_done      (tally_done),
    .total_correct   (total_correct),
    .total_seen      (total_seen),
    .label_err       (label_err),
    .busy            (busy),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .rd_class        (rd_class),
    .rd_correct      (rd_correct),
    .rd_total        (rd_total),
    .readout_done    (readout_done)
  );

  am_class_accuracy_tally #(.NUM_CLASSES(4), .CLASS_W(2), .CNT_W(4)) dut_small (
    .clk             (clk),
    .nrst            (nrst),
    .start           (s_start),
    .tally_valid     (s_valid),
    .correct_class   (s_cc),
    .class_inference (s_ci),
    .tally_done      (s_done),
    .total_correct   (s_total_correct),
    .total_seen      (s_total_seen),
    .label_err       (s_label_err),
    .busy            (s_busy),
    .rd_valid        (s_rd_valid),
    .rd_ready        (s_rdy),
    .rd_class        (s_rd_class),
    .rd_correct      (s_rd_correct),
    .rd_total        (s_rd_total),
    .readout_done    (s_readout_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Reference model: what the counters must hold after each accepted sample
  int m_seen, m_corr, m_err, m_busy;
  bit m_tally_on;
  int m_ct [N];
  int m_cc [N];
  int r_c [N];
  int r_t [N];

  function automatic int bump(input int v, input int w);
`ifdef TALLY_SATURATE_EN
    return (v == (1 << w) - 1) ? v : v + 1;
`else
    return (v + 1) % (1 << w);
`endif
  endfunction

  function automatic void m_clear();
    m_seen = 0;
    m_corr = 0;
    m_err  = 0;
    for (int i = 0; i < N; i++) begin
      m_ct[i] = 0;
      m_cc[i] = 0;
    end
  endfunction

  function automatic void m_tally(input int t, input int inf);
    m_seen = bump(m_seen, W);
    if (t == inf) m_corr = bump(m_corr, W);
    if (t < N) begin
      m_ct[t] = bump(m_ct[t], W);
      if (t == inf) m_cc[t] = bump(m_cc[t], W);
    end else begin
      m_err = 1;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of the tally outputs against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("total_seen", int'(total_seen), m_seen);
      chk("total_correct", int'(total_correct), m_corr);
      chk("label_err", int'(label_err), m_err);
      chk("busy", int'(busy), m_busy);
      chk("correct_le_seen", int'(total_correct <= total_seen), 1);
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    m_clear();
    m_busy = 1;
    m_tally_on = 1'b1;
    #1 start = 1'b0;
  endtask

  task automatic sample(input int t, input int inf, input bit done);
    tally_valid     = 1'b1;
    correct_class   = CW'(t);
    class_inference = CW'(inf);
    tally_done      = done;
    @(posedge clk);
    if (m_tally_on) begin
      m_tally(t, inf);
      if (done) m_tally_on = 1'b0;
    end
    #1;
    tally_valid = 1'b0;
    tally_done  = 1'b0;
  endtask

  task automatic start_with_valid_done(input int t, input int inf);
    start = 1'b1;
    tally_valid = 1'b1;
    tally_done = 1'b1;
    correct_class = CW'(t);
    class_inference = CW'(inf);
    @(posedge clk);
    m_clear();
    m_busy = 1;
    m_tally_on = 1'b1;
    #1;
    start = 1'b0;
    tally_valid = 1'b0;
    tally_done = 1'b0;
  endtask

  task automatic readout(input bit stall, input int nrec);
    int hc, ht, hcls;
    @(negedge clk);
    chk("rd_valid_at_entry", int'(rd_valid), 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < nrec; k++) begin
      if (stall) begin
        rd_ready = 1'b0;
        @(negedge clk);
        hcls = int'(rd_class);
        hc   = int'(rd_correct);
        ht   = int'(rd_total);
        chk("rd_valid_stalled", int'(rd_valid), 1);
        @(posedge clk);
        #1;
      end
      rd_ready = 1'b1;
      @(negedge clk);
      chk("rd_valid", int'(rd_valid), 1);
      chk("rd_class", int'(rd_class), k);
      chk("rd_correct", int'(rd_correct), m_cc[k]);
      chk("rd_total", int'(rd_total), m_ct[k]);
      if (stall) begin
        chk("stall_hold_class", int'(rd_class), hcls);
        chk("stall_hold_correct", int'(rd_correct), hc);
        chk("stall_hold_total", int'(rd_total), ht);
      end
      r_c[k] = int'(rd_correct);
      r_t[k] = int'(rd_total);
      @(posedge clk);
      if (k == N - 1) m_busy = 0;
      #1 rd_ready = 1'b0;
    end
    if (nrec == N) begin
      @(negedge clk);
      chk("readout_done_pulse", int'(readout_done), 1);
      chk("rd_valid_after_last", int'(rd_valid), 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("readout_done_single", int'(readout_done), 0);
      @(posedge clk);
      #1;
    end
  endtask

  int  exp4;
  bit  found;
  int  s_c1, s_t1;

  initial begin
    nrst = 1'b0;
    start = 1'b0; tally_valid = 1'b0; tally_done = 1'b0; rd_ready = 1'b0;
    correct_class = '0; class_inference = '0;
    s_start = 1'b0; s_valid = 1'b0; s_done = 1'b0; s_rdy = 1'b1;
    s_cc = '0; s_ci = '0;
    m_clear();
    m_busy = 0;
    m_tally_on = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_total_seen", int'(total_seen), 0);
    chk("reset_total_correct", int'(total_correct), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rd_valid", int'(rd_valid), 0);
    chk("reset_readout_done", int'(readout_done), 0);
    @(posedge clk);
    #1 nrst = 1'b1;
    check_en = 1'b1;

    // Ten class-3 samples, seven right, last one coincident with tally_done
    do_start();
    for (int k = 0; k < 10; k++) sample(3, (k < 7) ? 3 : 5, k == 9);
    readout(1'b1, N);
    @(negedge clk);
    chk("t1_total_seen_lit", int'(total_seen), 10);
    chk("t1_total_correct_lit", int'(total_correct), 7);
    chk("t1_cls3_correct_lit", r_c[3], 7);
    chk("t1_cls3_total_lit", r_t[3], 10);
    chk("t1_cls0_total_lit", r_t[0], 0);
    chk("t1_busy_idle_lit", int'(busy), 0);

    // Samples in IDLE are ignored
    @(posedge clk); #1;
    sample(4, 4, 1'b0);

    // start re-clears in TALLY and beats a coincident valid and done
    do_start();
    sample(2, 2, 1'b0);
    sample(6, 1, 1'b0);
    start_with_valid_done(2, 2);
    sample(0, 0, 1'b0);
    sample(1, 2, 1'b0);
    sample(25, 25, 1'b0);
    sample(30, 30, 1'b0);
    sample(30, 1, 1'b0);
    sample(2, 2, 1'b0);
    tally_done = 1'b1;
    @(posedge clk);
    m_tally_on = 1'b0;
    #1 tally_done = 1'b0;
    readout(1'b0, N);
    @(negedge clk);
    chk("t2_total_seen_lit", int'(total_seen), 6);
    chk("t2_total_correct_lit", int'(total_correct), 4);
    chk("t2_label_err_lit", int'(label_err), 1);
    chk("t2_cls25_correct_lit", r_c[25], 1);
    chk("t2_cls1_total_lit", r_t[1], 1);
    chk("t2_cls1_correct_lit", r_c[1], 0);
    chk("t2_cls2_total_lit", r_t[2], 1);

    // start during READOUT aborts without readout_done
    @(posedge clk); #1;
    do_start();
    sample(4, 4, 1'b0);
    sample(4, 1, 1'b1);
    readout(1'b0, 3);
    do_start();
    @(negedge clk);
    chk("abort_rd_valid", int'(rd_valid), 0);
    chk("abort_readout_done", int'(readout_done), 0);
    chk("abort_seen_cleared_lit", int'(total_seen), 0);

    // Async reset in the middle of the readout at index 5
    @(posedge clk); #1;
    sample(7, 7, 1'b0);
    sample(7, 7, 1'b0);
    sample(8, 7, 1'b1);
    readout(1'b0, 5);
    nrst = 1'b0;
    m_clear();
    m_busy = 0;
    m_tally_on = 1'b0;
    #1;
    chk("rst_mid_total_seen", int'(total_seen), 0);
    chk("rst_mid_total_correct", int'(total_correct), 0);
    chk("rst_mid_rd_valid", int'(rd_valid), 0);
    chk("rst_mid_readout_done", int'(readout_done), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_rd_class", int'(rd_class), 0);
    chk("rst_mid_rd_total", int'(rd_total), 0);
    @(posedge clk);
    #1 nrst = 1'b1;
    do_start();
    sample(9, 9, 1'b0);
    sample(9, 8, 1'b1);
    readout(1'b0, N);
    @(negedge clk);
    chk("post_rst_seen_lit", int'(total_seen), 2);
    chk("post_rst_correct_lit", int'(total_correct), 1);
    chk("post_rst_cls9_total_lit", r_t[9], 2);
    chk("post_rst_cls7_total_lit", r_t[7], 0);

    // Narrow counters: 20 correct class-1 samples
`ifdef TALLY_SATURATE_EN
    exp4 = 15;
`else
    exp4 = 4;
`endif
    @(posedge clk); #1;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      s_valid = 1'b1; s_cc = 2'd1; s_ci = 2'd1; s_done = (k == 19);
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_done = 1'b0;
    found = 1'b0;
    s_c1 = -1; s_t1 = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (s_rd_valid && s_rd_class == 2'd1 && !found) begin
        found = 1'b1;
        s_c1 = int'(s_rd_correct);
        s_t1 = int'(s_rd_total);
      end
    end
    chk("small_total_seen", int'(s_total_seen), exp4);
    chk("small_total_correct", int'(s_total_correct), exp4);
    chk("small_cls1_found", int'(found), 1);
    chk("small_cls1_correct", s_c1, exp4);
    chk("small_cls1_total", s_t1, exp4);
    chk("small_busy_end", int'(s_busy), 0);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
